ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

PS/2 keyboard receiver that feeds scan codes to the Orao machine. The Orao's `ps2clk`/`ps2data` inputs are currently tied idle. This block sits between the board's PS/2 pins and the keyboard matrix emulation, on the 25 MHz pixel clock domain. It synchronises and deglitches the PS/2 lines, deframes 11-bit device-to-host frames, checks parity, stop bit and timeout, and buffers accepted bytes in a small FIFO behind a valid/ready handshake.

## Interface
Parameters:
- `CLK_HZ`, 25000000: `clk` frequency, used to derive the timeout.
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock changes; range 2..15.
- `TIMEOUT_US`, 2000: maximum gap between PS/2 clock falling edges inside a frame.
- `FIFO_DEPTH_LOG2`, 3: FIFO holds 2^N bytes (default 8).

Ports:
- `clk`  in  1  system clock, 25 MHz pixel clock.
- `n_reset`  in  1  reset, asynchronous assert, active-low.
- `ps2clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2data`  in  1  raw PS/2 data pin, asynchronous.
- `code_valid`  out  1  FIFO head is valid.
- `code_ready`  in  1  consumer accepts the head this cycle.
- `code`  out  8  scan code at the FIFO head.
- `code_ext`  out  1  head was preceded by an E0 prefix.
- `code_brk`  out  1  head was preceded by an F0 (break) prefix.
- `frame_err`  out  1  one-cycle pulse on a parity, stop or timeout error.
- `overflow`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- `fifo_level`  out  FIFO_DEPTH_LOG2+1  current occupancy.

## Operation
- **Input conditioning.** `ps2clk` and `ps2data` each pass through a 2-FF synchroniser. The filtered clock `fclk` takes the synced value only after `FILTER_LEN` consecutive identical samples. Reset value of `fclk` is 1.
- **Edge detection.** A registered detector marks a falling edge of `fclk`. On that edge, the synced `ps2data` is sampled.
- **Frame FSM.** States are IDLE, DATA, PARITY, STOP.
  - IDLE: a falling edge with data=0 goes to DATA. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shifts 8 bits, LSB first, using a 3-bit counter, then goes to PARITY.
  - PARITY: stores the parity bit and goes to STOP.
  - STOP: data=1 and odd parity over data+parity means the byte is accepted. Any other combination pulses `frame_err` and drops the byte. The FSM returns to IDLE in both cases.
- **Timeout.** `TIMEOUT_CYC = (CLK_HZ/1000000)*TIMEOUT_US`. The counter clears on every falling edge and runs only when the FSM is not in IDLE. Reaching `TIMEOUT_CYC` sends the FSM to IDLE and pulses `frame_err`; the partial byte is discarded.
- **FIFO.** First-word fall-through.
  - `code_valid` = not empty. `code`, `code_ext` and `code_brk` show the head.
  - A pop occurs when `code_valid && code_ready`.
  - A push while full is dropped and pulses `overflow`. The contents are unchanged.
  - A push and pop in the same cycle while full both succeed, with no overflow.
  - A push and pop in the same cycle while empty: the push succeeds and the pop is a no-op.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2. `fifo_level` is the pointer difference using one extra bit.
- **Reset.** Asserting `n_reset` at any point, including mid-frame, immediately clears all of the following: the FSM (to IDLE), the shift register, the timeout counter, the FIFO pointers, and the prefix flags. All outputs go to 0.

## Timing
- Reset values: `code_valid`=0, `code`=0x00, `code_ext`=0, `code_brk`=0, `frame_err`=0, `overflow`=0, `fifo_level`=0.
- Latency: `code_valid` rises exactly `FILTER_LEN`+4 `clk` cycles after the `ps2clk` pin falls for the stop bit. This assumes the pins are clean and the FIFO was empty.
- `frame_err` and `overflow` are single-cycle pulses. They assert `FILTER_LEN`+3 cycles after the stop-bit edge, or in the cycle the timeout is reached.
- `code_ready` is sampled every cycle and has no combinational path to `code_valid`. The head advances in the cycle after the pop.
- Glitches on `ps2clk` shorter than `FILTER_LEN` cycles produce no edge.

## Configuration
- Macro: `PS2_PREFIX_DECODE_EN`.
- Defined:
  - An accepted 0xE0 sets `ext_pending`; an accepted 0xF0 sets `brk_pending`. Neither byte is pushed.
  - The next other byte is pushed with `code_ext`=`ext_pending` and `code_brk`=`brk_pending`, and both flags then clear.
  - A `frame_err` also clears both flags.
  - 0xE1 is treated as an ordinary byte.
- Undefined: every accepted byte is pushed raw, and `code_ext`/`code_brk` are tied 0.

## Test plan
- Send frame 0x1C, with parity 0 and stop 1, at a 12.5 kHz PS/2 clock. Expect `code_valid` after `FILTER_LEN`+4 cycles with `code`=0x1C and ext/brk=0. Asserting `code_ready` for one cycle leaves `fifo_level`=0.
- Send 0xE0, 0xF0, 0x75.
  - With the macro defined: a single entry with `code`=0x75, `code_ext`=1, `code_brk`=1.
  - With the macro undefined: three entries, 0xE0, 0xF0, 0x75, with flags 0.
- Send 0x1C with the parity bit flipped: one `frame_err` pulse and `fifo_level` stays 0. A following good 0x1C is received normally.
- Send a start bit plus 4 data bits, then hold `ps2clk` high: `frame_err` pulses `TIMEOUT_CYC` cycles after the last edge. The next full frame (0x29) is received correctly.
- Hold `code_ready`=0 and send 9 bytes, 0x01..0x09: `fifo_level`=8, one `overflow` pulse on the 9th byte, and the head stays 0x01. Draining yields 0x01..0x08.
- Inject a 3-cycle low glitch on `ps2clk` in IDLE, then assert `n_reset` mid-frame: there is no edge and no error. After release, all outputs are 0 and the next 0x1C frame is received.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host frame receiver with scan-code FIFO.
// Optional feature macro PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into code_ext/code_brk.
module ps2_keyboard_rx #(
  parameter int CLK_HZ          = 25000000,
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_US      = 2000,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     ps2clk,
  input  logic                     ps2data,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [7:0]               code,
  output logic                     code_ext,
  output logic                     code_brk,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
  localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int DEPTH       = 1 << FIFO_DEPTH_LOG2;
  localparam int L           = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic [3:0]    filt_cnt_q;
  logic          fclk_q, fclk_prev_q, fall, din, accept;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d, push_q, push_d;
  logic [9:0]    push_data_q, push_data_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [9:0]    mem [DEPTH];
  logic [L:0]    wr_ptr_q, rd_ptr_q;
  logic          full, pop, wr_en;

  assign fall = fclk_prev_q & ~fclk_q;
  assign din  = dat_sync_q[1];

  // Synchronise both pins and only let the clock change after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_cnt_q  <= '0;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk};
      dat_sync_q  <= {dat_sync_q[0], ps2data};
      fclk_prev_q <= fclk_q;
      if (clk_sync_q[1] == fclk_q) filt_cnt_q <= '0;
      else if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
        fclk_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else filt_cnt_q <= filt_cnt_q + 4'd1;
    end
  end

  // Frame deframer, timeout watchdog and prefix folding; produces one push or error pulse per frame.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    err_d       = 1'b0;
    push_d      = 1'b0;
    accept      = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    tmo_d       = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d   = din ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          accept  = din & (^{shift_q, par_q});
          err_d   = ~accept;
        end
      endcase
    end
    push_data_d = accept ? {brk_q, ext_q, shift_q} : push_data_q;
`ifdef PS2_PREFIX_DECODE_EN
    if (err_d) {ext_d, brk_d} = 2'b00;
    if (accept && shift_q == 8'hE0) ext_d = 1'b1;
    else if (accept && shift_q == 8'hF0) brk_d = 1'b1;
    else if (accept) begin
      push_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end
`else
    ext_d  = 1'b0;
    brk_d  = 1'b0;
    push_d = accept;
`endif
  end

  // State registers for the deframer and the FIFO pointers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      wr_ptr_q    <= wr_ptr_q + (L + 1)'(wr_en);
      rd_ptr_q    <= rd_ptr_q + (L + 1)'(pop);
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[L-1:0]] <= push_data_q;
  end

  assign full       = wr_ptr_q == {~rd_ptr_q[L], rd_ptr_q[L-1:0]};
  assign code_valid = wr_ptr_q != rd_ptr_q;
  assign pop        = code_valid & code_ready;
  assign wr_en      = push_q & (~full | pop);
  assign overflow   = push_q & full & ~pop;
  assign frame_err  = err_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign {code_brk, code_ext, code} = code_valid ? mem[rd_ptr_q[L-1:0]] : 10'd0;
endmodule
